// File: rtl/async_request_arbiter_pkg.sv
// Shared types and limits for the asynchronous request arbiter.
package arbiter_pkg;

    localparam int MAX_N = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_t;

endpackage

// File: rtl/async_request_arbiter_if.sv
// Request/grant bundle between the raw request pins, the arbiter and the shared resource.
interface async_request_arbiter_if #(
    parameter int N = 4
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   Request_i;
    logic           Done_i;
    logic           Start_o;
    logic [N-1:0]   Grant_o;
    logic [IDW-1:0] GrantId_o;
    logic           Busy_o;
    logic [N-1:0]   Pending_o;
    logic [N-1:0]   Overrun_o;
    logic           Timeout_o;

    modport slave (
        input  Request_i, Done_i,
        output Start_o, Grant_o, GrantId_o, Busy_o, Pending_o, Overrun_o, Timeout_o
    );

    modport master (
        output Request_i, Done_i,
        input  Start_o, Grant_o, GrantId_o, Busy_o, Pending_o, Overrun_o, Timeout_o
    );

endinterface

// File: rtl/async_request_arbiter_sync.sv
// Two-flop synchronizer plus a history flop per line; flags a rising edge of the synchronized level.
module request_synchronizer #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_req,
    output logic [WIDTH-1:0] o_edge
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= i_req;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_edge = r_sync2 & ~r_prev;

endmodule

// File: rtl/async_request_arbiter.sv
// Latches synchronized request edges and grants one shared resource round-robin
// through a Start/Done handshake with an optional BUSY timeout.
module async_request_arbiter
    import arbiter_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 0
) (
    input logic                    Clock,
    input logic                    Reset,
    async_request_arbiter_if.slave bus
);

    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    state_t         r_state;
    logic [N-1:0]   r_pending;
    logic [N-1:0]   r_grant;
    logic [N-1:0]   r_overrun;
    logic [IDW-1:0] r_grant_id;
    logic [IDW-1:0] r_last;
    logic           r_start;
    logic           r_busy;
    logic           r_timeout;

    logic [N-1:0]   w_edge;
    logic [N-1:0]   w_clear;
    logic [N-1:0]   w_win_onehot;
    logic [IDW-1:0] w_win_id;
    logic           w_win_valid;
    logic           w_take;
    logic           w_tmo;

    request_synchronizer #(
        .WIDTH(N)
    ) u_sync (
        .i_clk   (Clock),
        .i_rst_n (Reset),
        .i_req   (bus.Request_i),
        .o_edge  (w_edge)
    );

    // Scan starts just after the last winner so every requester gets a turn.
    always_comb begin
        int idx;
        idx         = 0;
        w_win_id    = '0;
        w_win_valid = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (int'(r_last) + int'(k)) % N;
            if (!w_win_valid && r_pending[IDW'(idx)]) begin
                w_win_valid = 1'b1;
                w_win_id    = IDW'(idx);
            end
        end
    end

    assign w_take       = (r_state == IDLE) && w_win_valid;
    assign w_win_onehot = N'(1) << w_win_id;
    assign w_clear      = w_take ? w_win_onehot : '0;

    generate
        if (TIMEOUT > 0) begin : g_tmo
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] r_count;

            always_ff @(posedge Clock) begin
                if (!Reset || r_state != BUSY) begin
                    r_count <= '0;
                end else if (r_count != CW'(TIMEOUT)) begin
                    r_count <= r_count + 1'b1;
                end
            end

            // Done has priority over an expiring timeout.
            assign w_tmo = (r_state == BUSY) && !bus.Done_i && (r_count == CW'(TIMEOUT - 1));
        end else begin : g_no_tmo
            assign w_tmo = 1'b0;
        end
    endgenerate

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state    <= IDLE;
            r_pending  <= '0;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_last     <= IDW'(N - 1);
            r_overrun  <= '0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            // A fresh edge on the bit being granted survives the clear.
            r_pending <= (r_pending & ~w_clear) | w_edge;
            r_overrun <= w_edge & r_pending & ~w_clear;
            r_start   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_win_valid) begin
                        r_state    <= START;
                        r_grant    <= w_win_onehot;
                        r_grant_id <= w_win_id;
                        r_last     <= w_win_id;
                        r_start    <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                START: begin
                    r_state <= BUSY;
                end
                BUSY: begin
                    if (bus.Done_i || w_tmo) begin
                        r_state    <= IDLE;
                        r_grant    <= '0;
                        r_grant_id <= '0;
                        r_busy     <= 1'b0;
                        r_timeout  <= w_tmo;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Start_o   = r_start;
    assign bus.Grant_o   = r_grant;
    assign bus.GrantId_o = r_grant_id;
    assign bus.Busy_o    = r_busy;
    assign bus.Pending_o = r_pending;
    assign bus.Overrun_o = r_overrun;
    assign bus.Timeout_o = r_timeout;

endmodule

// File: tb/tb_async_request_arbiter.sv
// Scoreboard bench for async_request_arbiter: directed request patterns, expected
// grants/overruns/timeouts queued at stimulus time and popped by an output monitor.
module tb_async_request_arbiter;

    localparam int N   = 4;
    localparam int TMO = 5;

    logic Clock = 1'b0;
    logic Reset;
    logic done_auto = 1'b0;
    logic done_man  = 1'b0;
    int   done_delay = -1;

    int total = 0;
    int bad   = 0;

    int unsigned  exp_grant[$];
    logic [N-1:0] exp_ovr[$];
    bit           exp_tmo[$];

    async_request_arbiter_if #(.N(N)) bus ();

    async_request_arbiter #(
        .N       (N),
        .TIMEOUT (TMO)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    assign bus.Done_i = done_auto | done_man;

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h want none", name, act);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_start"},   32'(bus.Start_o),   32'd0);
        check({pfx, "_grant"},   32'(bus.Grant_o),   32'd0);
        check({pfx, "_gid"},     32'(bus.GrantId_o), 32'd0);
        check({pfx, "_busy"},    32'(bus.Busy_o),    32'd0);
        check({pfx, "_pending"}, 32'(bus.Pending_o), 32'd0);
        check({pfx, "_overrun"}, 32'(bus.Overrun_o), 32'd0);
        check({pfx, "_timeout"}, 32'(bus.Timeout_o), 32'd0);
    endtask

    task automatic wait_start(input string name);
        int unsigned n;
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (bus.Start_o !== 1'b1 && n < 100);
        check(name, 32'(bus.Start_o), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int unsigned n;
        n = 0;
        while (n < 400 && !(exp_grant.size() == 0 && bus.Busy_o === 1'b0 && bus.Pending_o === '0)) begin
            @(negedge Clock);
            n++;
        end
        check(name, 32'(n < 400), 32'd1);
        repeat (4) @(posedge Clock);
        #1;
    endtask

    task automatic drop_all();
        bus.Request_i = '0;
        repeat (4) @(posedge Clock);
        #1;
    endtask

    // Monitor: every presented grant, overrun and timeout pulse must match a queued expectation.
    initial begin
        int unsigned  id;
        logic [N-1:0] m;
        forever begin
            @(negedge Clock);
            if (bus.Start_o === 1'b1) begin
                if (exp_grant.size() == 0) begin
                    flag("unexpected_grant", 32'(bus.GrantId_o));
                end else begin
                    id = exp_grant.pop_front();
                    check("grant_id", 32'(bus.GrantId_o), 32'(id));
                    check("grant_onehot", 32'(bus.Grant_o), 32'd1 << id);
                end
            end
            if (bus.Timeout_o === 1'b1) begin
                if (exp_tmo.size() == 0) flag("unexpected_timeout", 32'd1);
                else begin
                    void'(exp_tmo.pop_front());
                    check("timeout_grant_dropped", 32'(bus.Grant_o), 32'd0);
                end
            end
            if (bus.Overrun_o !== '0) begin
                if (exp_ovr.size() == 0) flag("unexpected_overrun", 32'(bus.Overrun_o));
                else begin
                    m = exp_ovr.pop_front();
                    check("overrun_mask", 32'(bus.Overrun_o), 32'(m));
                end
            end
        end
    end

    // Resource model: answers Start_o with Done_i in BUSY cycle done_delay (negative = silent).
    initial begin
        int d;
        forever begin
            @(negedge Clock);
            if (bus.Start_o === 1'b1 && done_delay >= 0) begin
                d = done_delay;
                repeat (d) @(posedge Clock);
                #1 done_auto = 1'b1;
                @(posedge Clock);
                #1 done_auto = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset         = 1'b0;
        bus.Request_i = 4'b1111;
        repeat (3) @(posedge Clock);
        #1;
        check_all_zero("reset");

        // Release with all lines high: edges seen right after reset, grants 0..3.
        done_delay = 2;
        exp_grant.push_back(0);
        exp_grant.push_back(1);
        exp_grant.push_back(2);
        exp_grant.push_back(3);
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        check("lat_e2_start", 32'(bus.Start_o), 32'd0);
        check("lat_e2_pending", 32'(bus.Pending_o), 32'hF);
        @(posedge Clock);
        #1;
        check("lat_e3_start", 32'(bus.Start_o), 32'd1);
        check("lat_e3_grant", 32'(bus.Grant_o), 32'h1);
        check("lat_e3_pending", 32'(bus.Pending_o), 32'hE);
        bus.Request_i = '0;
        wait_idle("idle_after_reset_grants");
        drop_all();

        // Round robin: 0,2,3 then 0,3.
        bus.Request_i = 4'b1101;
        exp_grant.push_back(0);
        exp_grant.push_back(2);
        exp_grant.push_back(3);
        wait_idle("idle_rr1");
        drop_all();
        bus.Request_i = 4'b1001;
        exp_grant.push_back(0);
        exp_grant.push_back(3);
        wait_idle("idle_rr2");
        drop_all();

        // Overrun: two edges on line 1 while 0 is busy.
        done_delay = 4;
        exp_grant.push_back(0);
        bus.Request_i[0] = 1'b1;
        wait_start("ovr_start0");
        bus.Request_i[1] = 1'b1;
        @(posedge Clock); #1 bus.Request_i[1] = 1'b0;
        @(posedge Clock); #1 bus.Request_i[1] = 1'b1;
        @(posedge Clock); #1 bus.Request_i[1] = 1'b0;
        exp_ovr.push_back(4'b0010);
        exp_grant.push_back(1);
        @(posedge Clock);
        @(posedge Clock);
        #1;
        check("ovr_pending", 32'(bus.Pending_o), 32'h2);
        wait_idle("idle_ovr");
        drop_all();

        // Set/clear collision on line 2.
        done_delay = -1;
        exp_grant.push_back(0);
        bus.Request_i[0] = 1'b1;
        wait_start("coll_start0");
        bus.Request_i[2] = 1'b1;
        @(posedge Clock); #1 bus.Request_i[2] = 1'b0;
        @(posedge Clock); #1;
        @(posedge Clock); #1 bus.Request_i[2] = 1'b1;
        @(posedge Clock); #1 done_man = 1'b1;
        @(posedge Clock); #1 done_man = 1'b0;
        check("coll_pending_before", 32'(bus.Pending_o), 32'h4);
        check("coll_idle_busy", 32'(bus.Busy_o), 32'd0);
        done_delay = 2;
        exp_grant.push_back(2);
        exp_grant.push_back(2);
        @(posedge Clock);
        #1;
        check("coll_pending_kept", 32'(bus.Pending_o), 32'h4);
        bus.Request_i = '0;
        wait_idle("idle_coll");
        drop_all();

        // Timeout without Done.
        done_delay = -1;
        exp_grant.push_back(3);
        exp_tmo.push_back(1'b1);
        bus.Request_i[3] = 1'b1;
        wait_start("tmo_start");
        repeat (5) @(posedge Clock);
        #1;
        check("tmo_busy5_timeout", 32'(bus.Timeout_o), 32'd0);
        check("tmo_busy5_grant", 32'(bus.Grant_o), 32'h8);
        @(posedge Clock);
        #1;
        check("tmo_pulse", 32'(bus.Timeout_o), 32'd1);
        check("tmo_grant_clear", 32'(bus.Grant_o), 32'd0);
        check("tmo_busy_clear", 32'(bus.Busy_o), 32'd0);
        drop_all();

        // Done in the fifth BUSY cycle beats the timeout.
        done_delay = 5;
        exp_grant.push_back(3);
        bus.Request_i[3] = 1'b1;
        wait_start("tmo2_start");
        repeat (6) @(posedge Clock);
        #1;
        check("tmo2_no_pulse", 32'(bus.Timeout_o), 32'd0);
        check("tmo2_grant_clear", 32'(bus.Grant_o), 32'd0);
        wait_idle("idle_tmo2");
        drop_all();

        // Reset in the middle of BUSY.
        done_delay = -1;
        exp_grant.push_back(0);
        bus.Request_i = 4'b0011;
        wait_start("mrst_start");
        @(posedge Clock);
        @(posedge Clock);
        #1;
        Reset         = 1'b0;
        bus.Request_i = '0;
        @(posedge Clock);
        #1;
        check_all_zero("mid_rst");
        Reset = 1'b1;
        repeat (10) @(posedge Clock);
        #1;
        check("mrst_no_pending", 32'(bus.Pending_o), 32'd0);
        check("mrst_no_busy", 32'(bus.Busy_o), 32'd0);
        done_delay = 2;
        exp_grant.push_back(1);
        bus.Request_i[1] = 1'b1;
        wait_idle("idle_mrst");
        drop_all();

        check("left_grants", 32'(exp_grant.size()), 32'd0);
        check("left_overruns", 32'(exp_ovr.size()), 32'd0);
        check("left_timeouts", 32'(exp_tmo.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/async_request_arbiter.md
# async_request_arbiter

Accepts N asynchronous level request lines (buttons, external strobes, foreign-clock flags), synchronizes each with a two-flop stage, and latches rising edges as pending requests. A round-robin scheduler then grants one shared downstream resource at a time, using a Start/Done handshake with an optional timeout. It sits between raw pins and a single shared service block, such as a UART transmitter, SPI master or display driver.

## Interface
- N, default 4: number of requesters, 1..16.
- TIMEOUT, default 0: max cycles in BUSY before abort; 0 disables the timeout.
- IDW, derived localparam: N>1 ? $clog2(N) : 1.

- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-low reset.
- Request_i  input  N  asynchronous level requests; a rising edge means one service request.
- Done_i  input  1  resource finished; sampled only in BUSY.
- Start_o  output  1  one-cycle pulse; the resource must latch GrantId_o.
- Grant_o  output  N  one-hot granted requester; all zero when idle.
- GrantId_o  output  IDW  binary index of the granted requester; 0 when idle.
- Busy_o  output  1  high in START and BUSY.
- Pending_o  output  N  latched, not-yet-granted requests.
- Overrun_o  output  N  one-cycle pulse: a new edge arrived while that bit was already pending.
- Timeout_o  output  1  one-cycle pulse when a grant is aborted by the timeout.

## Operation
- Per bit: sync1 <= Request_i; sync2 <= sync1; prev <= sync2; edge = sync2 & ~prev.
- Pending update, per bit:
  - set on edge;
  - cleared when the bit is granted (IDLE→START);
  - a set and a clear in the same cycle leave the bit set (the new request is kept).
- Overrun_o[i] = edge[i] & Pending_o[i] & ~clear[i]. The request is merged, not counted.
- Round-robin pointer `last`, reset value N-1, so requester 0 has first priority.
  - Search order: last+1, last+2, … mod N.
  - The first pending bit wins; `last` is updated to the winner.
- FSM states:
  - IDLE → START when Pending_o is non-zero. Register the winner into Grant_o/GrantId_o, clear its pending bit.
  - START → BUSY unconditionally. Start_o = 1 in START only.
  - BUSY → IDLE on Done_i = 1. Grant_o and GrantId_o clear on that edge.
  - BUSY → IDLE when the timeout counter reaches TIMEOUT-1 with Done_i low. Timeout_o pulses for one cycle and the grant is dropped; the pending bit is not restored.
- Done_i is ignored in IDLE and START.
- If Done_i and the timeout occur in the same cycle, Done wins and Timeout_o stays 0.
- Timeout counter:
  - width $clog2(TIMEOUT+1);
  - cleared on BUSY entry, increments each BUSY cycle;
  - saturates, never wraps;
  - absent when TIMEOUT = 0.
- One IDLE cycle always separates consecutive grants.

## Timing
- Reset (Reset = 0 at a rising edge):
  - state IDLE, last = N-1, all sync/prev/pending/counter flops 0;
  - all outputs 0.
  - Mid-operation reset aborts the grant with no Timeout_o pulse.
- Request latency: Request_i first sampled high at edge E0 → sync2 high after E1 → pending set at E2 → START entered at E3.
  - Start_o and Grant_o are high in the cycle after E3.
- A request shorter than one clock period may be missed; a stable level of at least 2 cycles is guaranteed to register.
- Re-arming: a high level produces one request only. The line must return low, be seen low at prev, then rise again.
- Minimum grant length: START (1 cycle) + BUSY (≥1 cycle) → Busy_o is high for at least 2 cycles.
- All outputs are registered; none is combinational from an input.

## Structure
- Package arbiter_pkg holds:
  - state encoding typedef (IDLE = 2'd0, START = 2'd1, BUSY = 2'd2);
  - max-N constant 16.
- Sub-module request_synchronizer (parameter WIDTH): two-flop plus prev stage, synchronous active-low reset, outputs edge[WIDTH-1:0].
- Top level: pending/overrun logic, round-robin pick, FSM, timeout counter.

## Test plan
- Reset: hold Reset = 0 with Request_i = 4'b1111 → all outputs 0. After release, Start_o fires at E3 with Grant_o = 4'b0001, GrantId_o = 0.
- Round robin: raise requests 0, 2 and 3 together; answer each Start_o with Done_i two cycles later → grant order 0, 2, 3. Re-raise 0 and 3 → order 0, 3.
- Overrun: two rising edges on Request_i[1] while requester 0 is BUSY → one Overrun_o[1] pulse, then exactly one grant to requester 1.
- Set/clear collision: a new edge on bit 2 lands in the same cycle bit 2 is granted → Pending_o[2] remains 1 and a second grant of 2 follows.
- Timeout (TIMEOUT = 5): grant with no Done_i → Timeout_o pulses after 5 BUSY cycles and Grant_o = 0. Repeat with Done_i in the fifth cycle → Timeout_o = 0.
- Reset mid-BUSY: pull Reset low while BUSY → next cycle all outputs 0, pending cleared, and no grant until a fresh edge.
